// File: rtl/nat_ingress_arbiter.sv
// Packet-granular round-robin arbiter in front of the NAT core.
// The grant is locked from the first beat to tlast. Beats carry the source port in tid.
module nat_ingress_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [ID_WIDTH-1:0]             m_axis_tid,
    output logic                            busy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                              state_q, state_d;
    logic [ID_WIDTH-1:0]                 grant_q, grant_d;
    logic [ID_WIDTH-1:0]                 last_q, last_d;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_last;
    logic                  sel_valid;
    logic                  eop;
    logic [ID_WIDTH:0]     pick;

    // Returns {found, port}: first requester at distance 1..span after base, wrapping.
    function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                  input logic [ID_WIDTH-1:0]  base,
                                                  input int                   span);
        int d;
        int best;
        logic [ID_WIDTH-1:0] idx;
        best = NUM_PORTS + 1;
        idx  = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            d = (j + NUM_PORTS - int'(base)) % NUM_PORTS;
            if (d == 0) d = NUM_PORTS;
            if (req[j] && d <= span && d < best) begin
                best = d;
                idx  = ID_WIDTH'(j);
            end
        end
        return {best <= span, idx};
    endfunction

    // The output mux always follows the registered grant, so it is also driven in IDLE.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_last  = s_axis_tlast[i];
                sel_valid = s_axis_tvalid[i];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            s_axis_tready[i] = (state_q == BUSY) && (grant_q == ID_WIDTH'(i)) && m_axis_tready;
    end

    assign m_axis_tdata  = sel_data;
    assign m_axis_tkeep  = sel_keep;
    assign m_axis_tlast  = sel_last;
    assign m_axis_tvalid = (state_q == BUSY) && sel_valid;
    assign m_axis_tid    = grant_q;
    assign busy          = (state_q == BUSY);
    assign pkt_count     = cnt_q;
    assign eop           = m_axis_tvalid && m_axis_tready && sel_last;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pick    = '0;
        case (state_q)
            IDLE: begin
                pick = rr_pick(s_axis_tvalid, last_q, NUM_PORTS);
                if (pick[ID_WIDTH]) begin
                    grant_d = pick[ID_WIDTH-1:0];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (eop) begin
                    for (int i = 0; i < NUM_PORTS; i++)
                        if (grant_q == ID_WIDTH'(i)) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    last_d = grant_q;
                    // The granted port's tvalid belongs to the beat just taken, so skip it.
                    pick = rr_pick(s_axis_tvalid, grant_q, NUM_PORTS - 1);
                    if (pick[ID_WIDTH]) grant_d = pick[ID_WIDTH-1:0];
                    else                state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_WIDTH'(NUM_PORTS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/nat_ingress_arbiter.md
Name: nat_ingress_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single NAT translation pipeline (64-bit AXI-Stream, Ethernet/IPv4/TCP 5-tuple parser plus connection-ID stage) between NUM_PORTS ingress streams. It sits directly in front of the NAT core. It locks the grant from first beat to tlast so packets are never interleaved, tags each beat with its source port, and keeps per-port forwarded-packet counters for software.

Parameters:
NUM_PORTS, 2, number of ingress streams (legal 2..8)
DATA_WIDTH, 64, tdata width per stream
KEEP_WIDTH, DATA_WIDTH/8, tkeep width per stream
ID_WIDTH, 3, width of m_axis_tid (must satisfy 2**ID_WIDTH >= NUM_PORTS)
CNT_WIDTH, 16, width of each per-port packet counter

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  per-port byte enables
s_axis_tlast  in  NUM_PORTS  per-port end of packet
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tready  out  NUM_PORTS  per-port ready
m_axis_tdata  out  DATA_WIDTH  to NAT core
m_axis_tkeep  out  KEEP_WIDTH  to NAT core
m_axis_tlast  out  1  to NAT core
m_axis_tvalid  out  1  to NAT core
m_axis_tready  in  1  from NAT core
m_axis_tid  out  ID_WIDTH  index of the granted port, valid with m_axis_tvalid
busy  out  1  high while a packet is granted (state BUSY)
pkt_count  out  NUM_PORTS*CNT_WIDTH  per-port count of packets forwarded (tlast handshakes)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, grant=0, last_grant=NUM_PORTS-1 (port 0 has top priority first), all pkt_count=0. Reset mid-packet abandons the packet with no flush; the upstream and NAT-core owners handle the partial packet.
- Outputs in IDLE: m_axis_tvalid=0, s_axis_tready=all 0, busy=0. m_axis_tdata/tkeep/tlast/tid are don't-care when m_axis_tvalid=0; drive the registered grant's values.
- IDLE: if any s_axis_tvalid is high, select the first requesting port scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS (last_grant itself is checked last). Register it into grant and go to BUSY. This gives a one-cycle arbitration bubble from IDLE; no beat transfers in the IDLE cycle.
- BUSY: pure combinational path with zero latency.
  - m_axis_tdata/tkeep/tlast/tvalid = s_axis_*[grant].
  - s_axis_tready[grant] = m_axis_tready; all other readys = 0.
  - m_axis_tid = grant; busy = 1.
- Beat handshake = m_axis_tvalid & m_axis_tready. A grant changes only on a handshake with m_axis_tlast=1. tvalid deasserting mid-packet keeps the grant, with no timeout.
- End of packet (tlast handshake in BUSY):
  - pkt_count[grant] += 1, wrapping modulo 2**CNT_WIDTH.
  - last_grant <= grant.
  - Back-to-back re-arbitration: scan the other ports in the same cycle in round-robin order starting at grant+1, excluding grant, because its tvalid belongs to the beat just consumed.
  - If another port requests, grant <= that port and stay BUSY, so its first beat can transfer the next cycle with no bubble. Otherwise go IDLE.
  - A port that sends continuously therefore alternates with any other requester and cannot starve it.
- Single-beat packets (tlast on the first beat) are legal and follow the same rules.
- The arbiter never modifies data, never drops beats and never reorders beats within a port.
- AXI-Stream rules hold on the master side: once m_axis_tvalid rises in BUSY it stays high with stable data until the handshake, because the granted upstream obeys AXI-Stream.

Test Plan:
- Reset/idle: rst held 2 cycles, no valids -> m_axis_tvalid=0, s_axis_tready=0, busy=0, pkt_count all 0, m_axis_tid=0.
- Single port: NUM_PORTS=2, port 1 sends one 8-beat NAT packet (beat 0 tdata[7:0]=0x01, beat 7 tlast) with m_axis_tready=1 -> first beat on the master one cycle after tvalid rises, 8 consecutive beats, m_axis_tid=1 on all, then IDLE, pkt_count[1]=1.
- Contention: both ports continuously valid with 8-beat packets, 64 packets total -> grants alternate 0,1,0,1 starting with port 0, no bubbles between packets, no interleaving, pkt_count = 32 and 32.
- Backpressure: m_axis_tready toggled pseudo-randomly 50% while port 0 packet is mid-stream and port 1 is requesting -> s_axis_tready[0] mirrors m_axis_tready, s_axis_tready[1] stays 0 until port 0's tlast handshake, data is bit-exact.
- Mid-packet reset: assert rst on beat 4 of a port 0 packet -> next cycle state is IDLE, all readys 0, counters 0; the next request from port 1 or port 0 gets a fresh grant with port 0 priority.
- Counter wrap: CNT_WIDTH=4, port 0 sends 17 single-beat packets -> pkt_count[0]=1.
